// File: rtl/z80_bus_arbiter.sv
// Arbitrates one external memory port between the Z80 core (wait-state driven) and a host requester (BUSRQ/BUSAK).
// Optional BUSRQ timeout with host_err abort is enabled by defining Z80_ARB_TIMEOUT_EN.
module z80_bus_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        z80_mreq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_dout,
  output logic [7:0]  z80_din,
  output logic        z80_wait_n,
  output logic        z80_busrq_n,
  input  logic        z80_busak_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        host_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || TIMEOUT < 1) begin : g_param_chk
    $error("z80_bus_arbiter: MEM_LAT must be 1..15 and TIMEOUT >= 1");
  end

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [2:0] {IDLE, Z_ACC, Z_DONE, BUSRQ, H_ACC, H_DONE, RELEASE} state_t;

  state_t     state;
  logic [3:0] lat_cnt;
  logic       acc_rd;
  logic       served;
  logic       zreq;
  logic       acc_done;
  logic       host_go;

  // served blocks a second access until the Z80 ends its cycle by raising mreq_n
  assign zreq     = !z80_mreq_n && (!z80_rd_n || !z80_wr_n) && z80_busak_n && !served;
  assign acc_done = acc_rd ? (lat_cnt == LAT) : (lat_cnt == 4'd1);

`ifdef Z80_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            host_blk;
  assign host_err = err_q;
  assign host_go  = host_req && !host_blk;
`else
  assign host_err = 1'b0;
  assign host_go  = host_req;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      acc_rd      <= 1'b0;
      served      <= 1'b0;
      z80_din     <= '0;
      z80_wait_n  <= 1'b1;
      z80_busrq_n <= 1'b1;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
`ifdef Z80_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      err_q       <= 1'b0;
      host_blk    <= 1'b0;
`endif
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      if (state == Z_ACC && acc_done) served <= 1'b1;
      else if (z80_mreq_n)            served <= 1'b0;
`ifdef Z80_ARB_TIMEOUT_EN
      err_q <= 1'b0;
      if (!host_req) host_blk <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (zreq) begin
            state      <= Z_ACC;
            mem_addr   <= z80_addr;
            mem_wdata  <= z80_dout;
            acc_rd     <= !z80_rd_n;
            mem_re     <= !z80_rd_n;
            mem_we     <= z80_rd_n;
            z80_wait_n <= 1'b0;
            lat_cnt    <= '0;
          end else if (host_go) begin
            state       <= BUSRQ;
            z80_busrq_n <= 1'b0;
`ifdef Z80_ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        Z_ACC: begin
          if (acc_done) begin
            if (acc_rd) z80_din <= mem_rdata;
            z80_wait_n <= 1'b1;
            state      <= Z_DONE;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        Z_DONE: state <= IDLE;
        BUSRQ: begin
          if (!z80_busak_n) begin
            state     <= H_ACC;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            acc_rd    <= !host_we;
            mem_re    <= !host_we;
            mem_we    <= host_we;
            lat_cnt   <= '0;
          end
`ifdef Z80_ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            err_q       <= 1'b1;
            z80_busrq_n <= 1'b1;
            host_blk    <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        H_ACC: begin
          if (acc_done) begin
            if (acc_rd) host_rdata <= mem_rdata;
            host_ack <= 1'b1;
            state    <= H_DONE;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        // First H_DONE cycle carries the ack; the next one decides between burst and release
        H_DONE: begin
          if (host_ack) begin
            host_ack <= 1'b0;
          end else if (host_req) begin
            state     <= H_ACC;
            mem_addr  <= host_addr;
            mem_wdata <= host_wdata;
            acc_rd    <= !host_we;
            mem_re    <= !host_we;
            mem_we    <= host_we;
            lat_cnt   <= '0;
          end else begin
            z80_busrq_n <= 1'b1;
            state       <= RELEASE;
          end
        end
        RELEASE: if (z80_busak_n) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Scoreboard bench for z80_bus_arbiter: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_z80_bus_arbiter;
  localparam int  LAT = 2;
  localparam int  TO  = 8;
  localparam time T   = 10;

  logic        wb_clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        z80_mreq_n = 1'b1, z80_rd_n = 1'b1, z80_wr_n = 1'b1;
  logic [15:0] z80_addr = '0;
  logic [7:0]  z80_dout = '0;
  logic [7:0]  z80_din;
  logic        z80_wait_n, z80_busrq_n;
  logic        z80_busak_n = 1'b1;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack, host_err;
  logic [7:0]  host_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata;

  z80_bus_arbiter #(.MEM_LAT(LAT), .TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .z80_mreq_n(z80_mreq_n), .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n),
    .z80_addr(z80_addr), .z80_dout(z80_dout), .z80_din(z80_din),
    .z80_wait_n(z80_wait_n), .z80_busrq_n(z80_busrq_n), .z80_busak_n(z80_busak_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #(T/2) wb_clk_i = ~wb_clk_i;

  // Memory model: read data appears exactly LAT cycles after the mem_re cycle, junk otherwise
  logic [LAT-1:0] re_hist = '0;
  logic [15:0]    addr_hist [LAT];
  always @(posedge wb_clk_i) begin
    re_hist      <= {re_hist[LAT-2:0], mem_re};
    addr_hist[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) addr_hist[i] <= addr_hist[i-1];
  end
  function automatic logic [7:0] rd_val(input logic [15:0] a);
    case (a)
      16'h1234: return 8'hA5;
      16'h0100: return 8'h3C;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction
  assign mem_rdata = re_hist[LAT-1] ? rd_val(addr_hist[LAT-1]) : 8'hEE;

  // Z80 bus-acknowledge model
  logic ak_stuck = 1'b0;
  int   ak_cnt = 0;
  always @(posedge wb_clk_i) begin
    if (z80_busrq_n) begin
      ak_cnt      <= 0;
      z80_busak_n <= 1'b1;
    end else if (!ak_stuck) begin
      if (ak_cnt == 2) z80_busak_n <= 1'b0;
      else             ak_cnt <= ak_cnt + 1;
    end
  end

  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef enum int {K_RE, K_WE, K_ZDONE, K_HACK, K_HERR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        host;
  } ev_t;
  ev_t exp_q[$];

  task automatic push(input kind_e k, input logic [15:0] a, input logic [7:0] d, input logic h);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.host = h;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input kind_e k, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", int'(k));
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (k == e.kind) begin
      case (k)
        K_RE: begin
          chk("mem_re_addr", a, e.addr);
          chk("mem_re_busak_n", z80_busak_n, !e.host);
        end
        K_WE: begin
          chk("mem_we_addr", a, e.addr);
          chk("mem_we_wdata", d, e.data);
          chk("mem_we_busak_n", z80_busak_n, !e.host);
        end
        K_ZDONE: begin
          chk("wait_low_cycles", a, e.addr);
          chk("z80_din", d, e.data);
        end
        K_HACK: chk("host_rdata", d, e.data);
        K_HERR: chk("busrq_cycles_to_err", a, e.addr);
        default: ;
      endcase
    end
  endtask

  // Monitor
  int   brq_falls = 0;
  initial begin
    int   wlow = 0;
    int   brq_cnt = 0;
    logic brq_in_z = 1'b0;
    logic prev_brq = 1'b1;
    forever begin
      @(negedge wb_clk_i);
      if (mem_re) chk("re_we_exclusive", mem_we, 1'b0);
      if (mem_re) check_ev(K_RE, mem_addr, 8'h00);
      if (mem_we) check_ev(K_WE, mem_addr, mem_wdata);
      if (host_ack) check_ev(K_HACK, 16'h0, host_rdata);
      if (!z80_busrq_n) begin
        if (prev_brq) begin brq_falls++; brq_cnt = 0; end
        brq_cnt++;
      end
      prev_brq = z80_busrq_n;
      if (host_err) check_ev(K_HERR, 16'(brq_cnt), 8'h00);
      if (z80_wait_n === 1'b0) begin
        wlow++;
        if (!z80_busrq_n) brq_in_z = 1'b1;
      end else if (wlow != 0) begin
        if (!z80_busrq_n) brq_in_z = 1'b1;
        chk("busrq_during_z80", brq_in_z, 1'b0);
        check_ev(K_ZDONE, 16'(wlow), z80_din);
        wlow = 0;
        brq_in_z = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_z80_din", z80_din, 8'h00);
    chk("rst_z80_wait_n", z80_wait_n, 1'b1);
    chk("rst_z80_busrq_n", z80_busrq_n, 1'b1);
    chk("rst_host_ack", host_ack, 1'b0);
    chk("rst_host_rdata", host_rdata, 8'h00);
    chk("rst_host_err", host_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
  endtask

  task automatic z80_cycle(input logic rd, input logic [15:0] a, input logic [7:0] d, input int hold);
    int n = 0;
    z80_addr = a; z80_dout = d;
    z80_mreq_n = 1'b0; z80_rd_n = !rd; z80_wr_n = rd;
    while (z80_wait_n && n < 60) begin tick(); n++; end
    while (!z80_wait_n && n < 60) begin tick(); n++; end
    if (n >= 60) begin
      tests++; fails++;
      $display("FAIL z80_cycle_timeout: waited %0d cycles, expected fewer than 60", n);
    end
    repeat (hold) tick();
    z80_mreq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1;
    tick();
  endtask

  task automatic host_cycle(input logic we, input logic [15:0] a, input logic [7:0] d, input logic keep);
    int n = 0;
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    do begin tick(); n++; end while (!host_ack && n < 100);
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL host_ack_timeout: waited %0d cycles, expected fewer than 100", n);
    end
    if (!keep) host_req = 1'b0;
  endtask

  task automatic wait_bus_free();
    int n = 0;
    while (!z80_busak_n && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL busak_release_timeout: waited %0d cycles, expected fewer than 50", n);
    end
    repeat (2) tick();
  endtask

  initial begin
    #(T * 20000);
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int falls0;
    repeat (2) tick();
    chk_reset();
    rst_n = 1'b1;
    tick();

    // Z80 read, mreq held low afterwards must not retrigger
    push(K_RE, 16'h1234, 8'h00, 1'b0);
    push(K_ZDONE, 16'(LAT + 1), 8'hA5, 1'b0);
    z80_cycle(1'b1, 16'h1234, 8'h00, 3);

    // Z80 writes, second only after mreq_n toggles
    push(K_WE, 16'h8000, 8'h5A, 1'b0);
    push(K_ZDONE, 16'd2, 8'hA5, 1'b0);
    z80_cycle(1'b0, 16'h8000, 8'h5A, 3);
    push(K_WE, 16'h8001, 8'hC3, 1'b0);
    push(K_ZDONE, 16'd2, 8'hA5, 1'b0);
    z80_cycle(1'b0, 16'h8001, 8'hC3, 0);
    chk("mem_addr_hold", mem_addr, 16'h8001);
    chk("mem_wdata_hold", mem_wdata, 8'hC3);

    // Host read
    push(K_RE, 16'h0100, 8'h00, 1'b1);
    push(K_HACK, 16'h0, 8'h3C, 1'b1);
    host_we = 1'b0; host_addr = 16'h0100; host_req = 1'b1;
    tick();
    chk("busrq_after_req", z80_busrq_n, 1'b0);
    n = 0;
    while (!host_ack && n < 100) begin tick(); n++; end
    host_req = 1'b0;
    chk("host_ack_seen", host_ack, 1'b1);
    tick();
    chk("host_ack_one_cycle", host_ack, 1'b0);
    chk("host_rdata_held", host_rdata, 8'h3C);
    wait_bus_free();
    chk("busrq_released", z80_busrq_n, 1'b1);

    // Simultaneous requests: Z80 first
    push(K_RE, 16'h1234, 8'h00, 1'b0);
    push(K_ZDONE, 16'(LAT + 1), 8'hA5, 1'b0);
    push(K_RE, 16'h0100, 8'h00, 1'b1);
    push(K_HACK, 16'h0, 8'h3C, 1'b1);
    fork
      z80_cycle(1'b1, 16'h1234, 8'h00, 1);
      host_cycle(1'b0, 16'h0100, 8'h00, 1'b0);
    join
    wait_bus_free();

    // Host write burst under a single bus grant
    falls0 = brq_falls;
    for (int i = 0; i < 3; i++) begin
      push(K_WE, 16'h2000 + 16'(i), 8'h10 + 8'(i), 1'b1);
      push(K_HACK, 16'h0, 8'h3C, 1'b1);
    end
    host_cycle(1'b1, 16'h2000, 8'h10, 1'b1);
    host_cycle(1'b1, 16'h2001, 8'h11, 1'b1);
    host_cycle(1'b1, 16'h2002, 8'h12, 1'b0);
    wait_bus_free();
    chk("burst_busrq_periods", brq_falls - falls0, 1);

    // Reset during H_ACC
    push(K_RE, 16'h0300, 8'h00, 1'b1);
    host_we = 1'b0; host_addr = 16'h0300; host_req = 1'b1;
    n = 0;
    while (!mem_re && n < 50) begin tick(); n++; end
    chk("reset_test_reached_hacc", mem_re, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_reset();
    host_req = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("busak_after_reset", z80_busak_n, 1'b1);
    push(K_RE, 16'h4455, 8'h00, 1'b0);
    push(K_ZDONE, 16'(LAT + 1), 8'h11, 1'b0);
    z80_cycle(1'b1, 16'h4455, 8'h00, 0);

`ifdef Z80_ARB_TIMEOUT_EN
    ak_stuck = 1'b1;
    push(K_HERR, 16'(TO), 8'h00, 1'b0);
    host_we = 1'b0; host_addr = 16'h0500; host_req = 1'b1;
    n = 0;
    while (!host_err && n < 40) begin tick(); n++; end
    chk("host_err_seen", host_err, 1'b1);
    chk("busrq_after_err", z80_busrq_n, 1'b1);
    host_req = 1'b0;
    repeat (5) tick();
    ak_stuck = 1'b0;
`else
    chk("host_err_tied", host_err, 1'b0);
`endif

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
